// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the single-port memory arbiter.
// The owner picker is kept here so the tie-break rule lives next to the owner encoding.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ArbIdle  = 2'd0,
    ArbIssue = 2'd1,
    ArbWait  = 2'd2,
    ArbResp  = 2'd3
  } arb_state_e;

  localparam logic ArbOwnIf  = 1'b0;
  localparam logic ArbOwnMem = 1'b1;

  // On a tie the port that did not win the previous grant goes next.
  function automatic logic pick_owner(input logic if_req, input logic mem_req,
                                      input logic last);
    if (if_req && mem_req) return !last;
    return mem_req ? ArbOwnMem : ArbOwnIf;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising icache/dcache requests onto one memory port,
// with reply routing back to the granted cache and timeout-driven re-issue.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_rep_o,
  output logic [63:0] if_rep_data_o,
  input  logic        mem_req_i,
  input  logic [31:0] mem_addr_i,
  input  logic        mem_write_i,
  input  logic [31:0] mem_write_data_i,
  input  logic [3:0]  mem_write_mask_i,
  output logic        mem_rep_o,
  output logic [63:0] mem_rep_data_o,
  output logic        ms_req_o,
  output logic [31:0] ms_addr_o,
  output logic        ms_write_o,
  output logic [31:0] ms_write_data_o,
  output logic [3:0]  ms_write_mask_o,
  input  logic        ms_rep_i,
  input  logic [63:0] ms_rep_data_i,
  output logic        busy_o,
  output logic        timeout_o
);

  localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

  arb_state_e  state;
  logic        owner;
  logic        last;
  logic [15:0] cnt;
  logic        grant_owner;

  assign grant_owner = pick_owner(if_req_i, mem_req_i, last);
  assign busy_o      = (state != ArbIdle);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= ArbIdle;
      owner           <= ArbOwnIf;
      last            <= 1'b1;
      cnt             <= '0;
      if_rep_o        <= 1'b0;
      if_rep_data_o   <= '0;
      mem_rep_o       <= 1'b0;
      mem_rep_data_o  <= '0;
      ms_req_o        <= 1'b0;
      ms_addr_o       <= '0;
      ms_write_o      <= 1'b0;
      ms_write_data_o <= '0;
      ms_write_mask_o <= '0;
      timeout_o       <= 1'b0;
    end else begin
      ms_req_o  <= 1'b0;
      timeout_o <= 1'b0;
      if_rep_o  <= 1'b0;
      mem_rep_o <= 1'b0;
      unique case (state)
        ArbIdle: begin
          if (if_req_i || mem_req_i) begin
            owner    <= grant_owner;
            last     <= grant_owner;
            cnt      <= '0;
            ms_req_o <= 1'b1;
            state    <= ArbIssue;
            if (grant_owner == ArbOwnMem) begin
              ms_addr_o       <= mem_addr_i;
              ms_write_o      <= mem_write_i;
              ms_write_data_o <= mem_write_data_i;
              ms_write_mask_o <= mem_write_mask_i;
            end else begin
              ms_addr_o       <= if_addr_i;
              ms_write_o      <= 1'b0;
              ms_write_data_o <= '0;
              ms_write_mask_o <= '0;
            end
          end
        end
        ArbIssue: state <= ArbWait;
        ArbWait: begin
          // A reply landing on the final wait cycle beats the re-issue.
          if (ms_rep_i) begin
            if (owner == ArbOwnMem) begin
              mem_rep_data_o <= ms_rep_data_i;
              mem_rep_o      <= 1'b1;
            end else begin
              if_rep_data_o <= ms_rep_data_i;
              if_rep_o      <= 1'b1;
            end
            state <= ArbResp;
          end else if (cnt == CntLast) begin
            cnt       <= '0;
            timeout_o <= 1'b1;
            ms_req_o  <= 1'b1;
            state     <= ArbIssue;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ArbResp: state <= ArbIdle;
        default: state <= ArbIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written corner
// sequences, and randomized traffic checked against a transaction-timeline model.
module tb_mem_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_rep_o;
  logic [63:0] if_rep_data_o;
  logic        mem_req_i = 1'b0;
  logic [31:0] mem_addr_i = '0;
  logic        mem_write_i = 1'b0;
  logic [31:0] mem_write_data_i = '0;
  logic [3:0]  mem_write_mask_i = '0;
  logic        mem_rep_o;
  logic [63:0] mem_rep_data_o;
  logic        ms_req_o;
  logic [31:0] ms_addr_o;
  logic        ms_write_o;
  logic [31:0] ms_write_data_o;
  logic [3:0]  ms_write_mask_o;
  logic        ms_rep_i = 1'b0;
  logic [63:0] ms_rep_data_i = '0;
  logic        busy_o;
  logic        timeout_o;

  mem_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_rep_o(if_rep_o), .if_rep_data_o(if_rep_data_o),
    .mem_req_i(mem_req_i), .mem_addr_i(mem_addr_i), .mem_write_i(mem_write_i),
    .mem_write_data_i(mem_write_data_i), .mem_write_mask_i(mem_write_mask_i),
    .mem_rep_o(mem_rep_o), .mem_rep_data_o(mem_rep_data_o),
    .ms_req_o(ms_req_o), .ms_addr_o(ms_addr_o), .ms_write_o(ms_write_o),
    .ms_write_data_o(ms_write_data_o), .ms_write_mask_o(ms_write_mask_o),
    .ms_rep_i(ms_rep_i), .ms_rep_data_i(ms_rep_data_i),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [63:0] held_if  = '0;
  logic [63:0] held_mem = '0;

  typedef struct {
    logic        is_mem;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    int unsigned lat;
    logic [63:0] rdata;
    logic        exp_wr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_mask;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ms_req"}, ms_req_o, 0);
    chk({tag, "_ms_addr"}, ms_addr_o, 0);
    chk({tag, "_ms_write"}, ms_write_o, 0);
    chk({tag, "_ms_wdata"}, ms_write_data_o, 0);
    chk({tag, "_ms_mask"}, ms_write_mask_o, 0);
    chk({tag, "_if_rep"}, if_rep_o, 0);
    chk({tag, "_mem_rep"}, mem_rep_o, 0);
    chk({tag, "_if_data"}, if_rep_data_o, 0);
    chk({tag, "_mem_data"}, mem_rep_data_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_timeout"}, timeout_o, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    if_req_i = 1'b0; mem_req_i = 1'b0; ms_rep_i = 1'b0;
    tick();
    chk_zero("reset");
    tick();
    rst = 1'b1;
    held_if = '0;
    held_mem = '0;
  endtask

  task automatic check_issue(input string tag, input logic [31:0] a, input logic w,
                             input logic [31:0] d, input logic [3:0] m);
    chk({tag, "_ms_req"}, ms_req_o, 1);
    chk({tag, "_ms_addr"}, ms_addr_o, a);
    chk({tag, "_ms_write"}, ms_write_o, w);
    chk({tag, "_ms_wdata"}, ms_write_data_o, d);
    chk({tag, "_ms_mask"}, ms_write_mask_o, m);
    chk({tag, "_busy"}, busy_o, 1);
  endtask

  // Starts just after the ISSUE cycle was observed; ends observing the following IDLE cycle.
  task automatic finish_txn(input string tag, input int unsigned lat,
                            input logic [63:0] rd, input logic is_mem);
    for (int unsigned k = 1; k <= lat; k++) begin
      tick();
      chk({tag, "_wait_ms_req"}, ms_req_o, 0);
      chk({tag, "_wait_if_rep"}, if_rep_o, 0);
      chk({tag, "_wait_mem_rep"}, mem_rep_o, 0);
      chk({tag, "_wait_busy"}, busy_o, 1);
      chk({tag, "_wait_timeout"}, timeout_o, 0);
      if (k == lat) begin
        ms_rep_i = 1'b1;
        ms_rep_data_i = rd;
      end
    end
    tick();
    ms_rep_i = 1'b0;
    ms_rep_data_i = {$urandom, $urandom};
    if (is_mem) held_mem = rd; else held_if = rd;
    chk({tag, "_if_rep"}, if_rep_o, !is_mem);
    chk({tag, "_mem_rep"}, mem_rep_o, is_mem);
    chk({tag, "_if_data"}, if_rep_data_o, held_if);
    chk({tag, "_mem_data"}, mem_rep_data_o, held_mem);
    chk({tag, "_resp_ms_req"}, ms_req_o, 0);
    chk({tag, "_resp_busy"}, busy_o, 1);
    if (is_mem) mem_req_i = 1'b0; else if_req_i = 1'b0;
    tick();
    chk({tag, "_idle_busy"}, busy_o, 0);
    chk({tag, "_idle_if_rep"}, if_rep_o, 0);
    chk({tag, "_idle_mem_rep"}, mem_rep_o, 0);
    chk({tag, "_idle_ms_req"}, ms_req_o, 0);
  endtask

  // Randomized traffic; the model tracks the transaction timeline by cycle number.
  task automatic random_run(input int ncyc);
    logic        x_msreq = 0, x_to = 0, x_ifrep = 0, x_memrep = 0, x_busy = 0;
    logic [31:0] e_addr = '0, e_data = '0;
    logic        e_wr = 0;
    logic [3:0]  e_mask = '0;
    logic        act = 0, own = 0, m_last = 1;
    int          idle_from = 0, issue_c = 0, resp_c = -1, m_due = -1;
    logic        in_wait;
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      chk("rnd_ms_req", ms_req_o, x_msreq);
      chk("rnd_timeout", timeout_o, x_to);
      chk("rnd_if_rep", if_rep_o, x_ifrep);
      chk("rnd_mem_rep", mem_rep_o, x_memrep);
      chk("rnd_busy", busy_o, x_busy);
      chk("rnd_ms_addr", ms_addr_o, e_addr);
      chk("rnd_ms_write", ms_write_o, e_wr);
      chk("rnd_ms_wdata", ms_write_data_o, e_data);
      chk("rnd_ms_mask", ms_write_mask_o, e_mask);
      chk("rnd_if_data", if_rep_data_o, held_if);
      chk("rnd_mem_data", mem_rep_data_o, held_mem);

      // Requesters: raise with fresh fields, drop when their reply arrives.
      if (x_ifrep) if_req_i = 1'b0;
      else if (!if_req_i && ($urandom_range(2) == 0)) begin
        if_req_i = 1'b1;
        if_addr_i = $urandom;
      end
      if (x_memrep) mem_req_i = 1'b0;
      else if (!mem_req_i && ($urandom_range(2) == 0)) begin
        mem_req_i = 1'b1;
        mem_addr_i = $urandom;
        mem_write_i = 1'($urandom_range(1));
        mem_write_data_i = $urandom;
        mem_write_mask_i = 4'($urandom_range(15));
      end

      // Memory: reply 1..TMO cycles after each strobe, sometimes never.
      if (x_msreq) m_due = ($urandom_range(7) == 0) ? c + 1000 : c + int'($urandom_range(TMO, 1));
      in_wait = act && (c > issue_c) && (resp_c < 0);
      ms_rep_data_i = {$urandom, $urandom};
      if (c == m_due) begin
        ms_rep_i = 1'b1;
        m_due = -1;
      end else begin
        ms_rep_i = (!in_wait && ($urandom_range(9) == 0));
      end

      x_msreq = 0; x_to = 0; x_ifrep = 0; x_memrep = 0; x_busy = 0;
      if (act) begin
        if (c == resp_c) begin
          act = 0;
          idle_from = c + 1;
        end else if (in_wait && ms_rep_i) begin
          resp_c = c + 1;
          x_busy = 1;
          if (own) begin x_memrep = 1; held_mem = ms_rep_data_i; end
          else begin x_ifrep = 1; held_if = ms_rep_data_i; end
        end else if (in_wait && c == issue_c + TMO) begin
          issue_c = c + 1;
          x_msreq = 1; x_to = 1; x_busy = 1;
        end else begin
          x_busy = 1;
        end
      end
      if (!act && c >= idle_from && (if_req_i || mem_req_i)) begin
        own = (if_req_i && mem_req_i) ? !m_last : mem_req_i;
        m_last = own;
        act = 1; issue_c = c + 1; resp_c = -1;
        x_msreq = 1; x_busy = 1;
        if (own) begin
          e_addr = mem_addr_i; e_wr = mem_write_i; e_data = mem_write_data_i; e_mask = mem_write_mask_i;
        end else begin
          e_addr = if_addr_i; e_wr = 0; e_data = '0; e_mask = '0;
        end
      end
    end
    if_req_i = 1'b0; mem_req_i = 1'b0; ms_rep_i = 1'b0;
  endtask

  initial begin
    vecs[0] = '{0, 32'h100, 1, 32'hCAFEF00D, 4'hF, 3, 64'h1122334455667788, 0, 32'h0, 4'h0};
    vecs[1] = '{1, 32'h2004, 1, 32'hDEADBEEF, 4'b0011, 2, 64'h0, 1, 32'hDEADBEEF, 4'b0011};
    vecs[2] = '{1, 32'h3000, 0, 32'h12345678, 4'hF, 1, 64'hA5A5A5A55A5A5A5A, 0, 32'h12345678, 4'hF};
    vecs[3] = '{0, 32'hFFFFFFFC, 1, 32'hFFFFFFFF, 4'hF, TMO, 64'hFFFFFFFFFFFFFFFF, 0, 32'h0, 4'h0};
    vecs[4] = '{1, 32'h0, 1, 32'hFFFFFFFF, 4'b1000, TMO, 64'h0BADF00D0BADF00D, 1, 32'hFFFFFFFF, 4'b1000};
    vecs[5] = '{0, 32'h40, 0, 32'h0, 4'h0, 1, 64'h0123456789ABCDEF, 0, 32'h0, 4'h0};

    do_reset();

    // Directed single-requester table; the non-requesting port's fields carry noise.
    for (int i = 0; i < 6; i++) begin
      mem_write_i = vecs[i].wr;
      mem_write_data_i = vecs[i].wdata;
      mem_write_mask_i = vecs[i].mask;
      if (vecs[i].is_mem) begin
        mem_req_i = 1'b1; mem_addr_i = vecs[i].addr;
      end else begin
        if_req_i = 1'b1; if_addr_i = vecs[i].addr; mem_addr_i = 32'h77777777;
      end
      tick();
      check_issue($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_wr,
                  vecs[i].exp_wdata, vecs[i].exp_mask);
      finish_txn($sformatf("vec%0d", i), vecs[i].lat, vecs[i].rdata, vecs[i].is_mem);
    end

    // Simultaneous requests after reset: IF, MEM, then IF, MEM again.
    do_reset();
    mem_write_i = 1'b0; mem_write_data_i = 32'h0; mem_write_mask_i = 4'h0;
    for (int p = 0; p < 2; p++) begin
      if_req_i = 1'b1; if_addr_i = 32'h500 + 32'(p);
      mem_req_i = 1'b1; mem_addr_i = 32'h600 + 32'(p);
      tick();
      check_issue("tie_if", 32'h500 + 32'(p), 0, 0, 0);
      finish_txn("tie_if", 2, 64'hAAAA0000 + 64'(p), 0);
      tick();
      check_issue("tie_mem", 32'h600 + 32'(p), 0, 0, 0);
      finish_txn("tie_mem", 3, 64'hBBBB0000 + 64'(p), 1);
    end

    // MEM raised while IF is in flight: served right after IF with no strobe overlap.
    if_req_i = 1'b1; if_addr_i = 32'h900;
    tick();
    check_issue("held_if", 32'h900, 0, 0, 0);
    mem_req_i = 1'b1; mem_addr_i = 32'hA00; mem_write_i = 1'b1;
    mem_write_data_i = 32'h13579BDF; mem_write_mask_i = 4'b0110;
    finish_txn("held_if", 4, 64'hC0C0C0C0C0C0C0C0, 0);
    tick();
    check_issue("held_mem", 32'hA00, 1, 32'h13579BDF, 4'b0110);
    finish_txn("held_mem", 1, 64'h0, 1);

    // No reply: re-strobe with timeout pulse every TMO+1 cycles, then normal completion.
    if_req_i = 1'b1; if_addr_i = 32'h700;
    tick();
    check_issue("to_first", 32'h700, 0, 0, 0);
    for (int r = 0; r < 2; r++) begin
      for (int k = 1; k <= TMO; k++) begin
        tick();
        chk("to_wait_ms_req", ms_req_o, 0);
        chk("to_wait_timeout", timeout_o, 0);
        chk("to_wait_busy", busy_o, 1);
      end
      tick();
      chk("to_retry_timeout", timeout_o, 1);
      check_issue("to_retry", 32'h700, 0, 0, 0);
    end
    finish_txn("to_done", 2, 64'hD00DD00DD00DD00D, 0);

    // Reset mid-WAIT abandons the transaction; a late memory reply is dropped.
    mem_req_i = 1'b1; mem_addr_i = 32'h8000; mem_write_i = 1'b1;
    mem_write_data_i = 32'h55AA55AA; mem_write_mask_i = 4'b0101;
    tick();
    check_issue("rstw", 32'h8000, 1, 32'h55AA55AA, 4'b0101);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_zero("rstw_in_reset");
    rst = 1'b1; mem_req_i = 1'b0;
    ms_rep_i = 1'b1; ms_rep_data_i = 64'hFEEDFACEFEEDFACE;
    held_if = '0; held_mem = '0;
    for (int k = 0; k < 2; k++) begin
      tick();
      ms_rep_i = 1'b0;
      chk("rstw_late_if_rep", if_rep_o, 0);
      chk("rstw_late_mem_rep", mem_rep_o, 0);
      chk("rstw_late_busy", busy_o, 0);
      chk("rstw_late_ms_req", ms_req_o, 0);
      chk("rstw_late_mem_data", mem_rep_data_o, 0);
    end

    do_reset();
    random_run(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
